// File: rtl/perf_sample_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : perf_sample_ctrl
// Brief    : CSR/sampler arbiter for the MHPM counter port with periodic scan
//            into a tagged sample FIFO. Optional macro: PERF_SAMPLE_TIMESTAMP_EN
// Revision : 1.0 - initial release
// ============================================================================
module perf_sample_ctrl #(
   parameter int NumCounters = 6,
   parameter int PeriodWidth = 16,
   parameter int FifoDepth   = 8,
   parameter int XLEN        = 64
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   csr_req_i,
   input  logic [11:0]            csr_addr_i,
   input  logic                   csr_we_i,
   input  logic [XLEN-1:0]        csr_wdata_i,
   output logic [XLEN-1:0]        csr_rdata_o,
   output logic [11:0]            perf_addr_o,
   output logic                   perf_we_o,
   output logic [XLEN-1:0]        perf_data_o,
   input  logic [XLEN-1:0]        perf_data_i,
   input  logic                   sample_en_i,
   input  logic [PeriodWidth-1:0] sample_period_i,
   input  logic [NumCounters-1:0] counter_mask_i,
   output logic                   sample_valid_o,
   input  logic                   sample_ready_i,
   output logic [3:0]             sample_idx_o,
   output logic [7:0]             sample_seq_o,
   output logic                   sample_last_o,
   output logic [XLEN-1:0]        sample_data_o,
   output logic [7:0]             drop_cnt_o,
   output logic                   busy_o
);

   localparam int          PtrW        = $clog2(FifoDepth);
   localparam int          CntW        = PtrW + 1;
   localparam logic [11:0] CounterBase = 12'hB03;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SCAN = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]      idx;
      logic [7:0]      seq;
      logic            last;
      logic [XLEN-1:0] data;
   } entry_t;

   state_e                 state_q, state_d;
   logic [PeriodWidth-1:0] period_q, period_d;
   logic [NumCounters-1:0] mask_q, mask_d;
   logic [3:0]             idx_q, idx_d;
   logic [7:0]             seq_q, seq_d;
   logic [7:0]             drop_q, drop_d;
   entry_t                 fifo_mem_q [FifoDepth];
   entry_t                 fifo_mem_d [FifoDepth];
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;

   logic                   push, pop;
   entry_t                 push_entry;
   entry_t                 head;
   logic [3:0]             first_idx, next_idx;
   logic                   scan_last;
   int                     mask_popcnt, req_slots, free_slots;
   logic                   hdr_pending;
   logic [XLEN-1:0]        ts_value;

`ifdef PERF_SAMPLE_TIMESTAMP_EN
   logic [63:0]            cycle_q, cycle_d;
   logic [XLEN-1:0]        ts_q, ts_d;
   logic                   hdr_q, hdr_d;

   assign hdr_pending = hdr_q;
   assign ts_value    = ts_q;
   assign cycle_d     = cycle_q + 64'd1;
`else
   assign hdr_pending = 1'b0;
   assign ts_value    = '0;
`endif

   // Mask decode: slot demand of the live mask and scan-walk helpers on mask_q.
   always_comb begin
      mask_popcnt = 0;
      first_idx   = '0;
      next_idx    = idx_q;
      scan_last   = 1'b1;
      for (int i = NumCounters - 1; i >= 0; i--) begin
         if (counter_mask_i[i]) begin
            first_idx   = 4'(i);
            mask_popcnt = mask_popcnt + 1;
         end
         if (mask_q[i] && (i > int'(idx_q))) begin
            next_idx  = 4'(i);
            scan_last = 1'b0;
         end
      end
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      req_slots = (mask_popcnt != 0) ? mask_popcnt + 1 : 0;
`else
      req_slots = mask_popcnt;
`endif
      free_slots = FifoDepth - int'(count_q);
   end

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      mask_d     = mask_q;
      idx_d      = idx_q;
      seq_d      = seq_q;
      drop_d     = drop_q;
      push       = 1'b0;
      push_entry = '0;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
      hdr_d      = hdr_q;
      ts_d       = ts_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (sample_en_i) begin
               period_d = sample_period_i;
               state_d  = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (!sample_en_i) begin
               state_d = ST_IDLE;
            end else if (period_q != '0) begin
               period_d = period_q - PeriodWidth'(1);
            end else begin
               mask_d = counter_mask_i;
               if (req_slots == 0) begin
                  period_d = sample_period_i;
               end else if (free_slots >= req_slots) begin
                  // Reserving every slot now means no push in SCAN can overflow.
                  state_d = ST_SCAN;
                  idx_d   = first_idx;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
                  hdr_d   = 1'b1;
                  ts_d    = cycle_q[XLEN-1:0];
`endif
               end else begin
                  if (drop_q != 8'hFF) begin
                     drop_d = drop_q + 8'd1;
                  end
                  period_d = sample_period_i;
               end
            end
         end
         ST_SCAN: begin
            if (!csr_req_i) begin
               push           = 1'b1;
               push_entry.seq = seq_q;
               if (hdr_pending) begin
                  push_entry.idx  = 4'hF;
                  push_entry.last = (mask_q == '0);
                  push_entry.data = ts_value;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
                  hdr_d           = 1'b0;
`endif
               end else begin
                  push_entry.idx  = idx_q;
                  push_entry.last = scan_last;
                  push_entry.data = perf_data_i;
                  if (scan_last) begin
                     seq_d    = seq_q + 8'd1;
                     period_d = sample_period_i;
                     state_d  = sample_en_i ? ST_WAIT : ST_IDLE;
                  end else begin
                     idx_d = next_idx;
                  end
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      pop        = (count_q != '0) && sample_ready_i;
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      if (push) begin
         fifo_mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d             = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // CSR file always wins the counter port; the sampler only ever reads.
   always_comb begin
      perf_addr_o = '0;
      perf_we_o   = 1'b0;
      perf_data_o = '0;
      if (csr_req_i) begin
         perf_addr_o = csr_addr_i;
         perf_we_o   = csr_we_i;
         perf_data_o = csr_wdata_i;
      end else if (state_q == ST_SCAN) begin
         perf_addr_o = CounterBase + {8'h00, idx_q};
      end
   end

   assign csr_rdata_o    = perf_data_i;
   assign head           = fifo_mem_q[rd_ptr_q];
   assign sample_valid_o = (count_q != '0);
   assign sample_idx_o   = sample_valid_o ? head.idx  : '0;
   assign sample_seq_o   = sample_valid_o ? head.seq  : '0;
   assign sample_last_o  = sample_valid_o ? head.last : 1'b0;
   assign sample_data_o  = sample_valid_o ? head.data : '0;
   assign drop_cnt_o     = drop_q;
   assign busy_o         = (state_q == ST_SCAN);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         period_q   <= '0;
         mask_q     <= '0;
         idx_q      <= '0;
         seq_q      <= '0;
         drop_q     <= '0;
         fifo_mem_q <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         mask_q     <= mask_d;
         idx_q      <= idx_d;
         seq_q      <= seq_d;
         drop_q     <= drop_d;
         fifo_mem_q <= fifo_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

`ifdef PERF_SAMPLE_TIMESTAMP_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cycle_q <= '0;
         ts_q    <= '0;
         hdr_q   <= 1'b0;
      end else begin
         cycle_q <= cycle_d;
         ts_q    <= ts_d;
         hdr_q   <= hdr_d;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_perf_sample_ctrl.sv
`default_nettype none
// Scoreboard bench for perf_sample_ctrl: stimulus queues expected samples,
// a monitor pops and compares them as the DUT streams them out.
module tb_perf_sample_ctrl;

   localparam int NC = 6;
   localparam int PW = 16;
   localparam int FD = 8;
   localparam int XL = 64;
`ifdef PERF_SAMPLE_TIMESTAMP_EN
   localparam int HDR = 1;
`else
   localparam int HDR = 0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          csr_req_i = 1'b0;
   logic [11:0]   csr_addr_i = '0;
   logic          csr_we_i = 1'b0;
   logic [XL-1:0] csr_wdata_i = '0;
   logic [XL-1:0] csr_rdata_o;
   logic [11:0]   perf_addr_o;
   logic          perf_we_o;
   logic [XL-1:0] perf_data_o;
   logic [XL-1:0] perf_data_i;
   logic          sample_en_i = 1'b0;
   logic [PW-1:0] sample_period_i = '0;
   logic [NC-1:0] counter_mask_i = '0;
   logic          sample_valid_o;
   logic          sample_ready_i = 1'b0;
   logic [3:0]    sample_idx_o;
   logic [7:0]    sample_seq_o;
   logic          sample_last_o;
   logic [XL-1:0] sample_data_o;
   logic [7:0]    drop_cnt_o;
   logic          busy_o;

   int checks = 0;
   int failures = 0;
   logic we_bad = 1'b0;

   always #5 clk = ~clk;

   perf_sample_ctrl #(
      .NumCounters(NC), .PeriodWidth(PW), .FifoDepth(FD), .XLEN(XL)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_we_i(csr_we_i),
      .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
      .perf_addr_o(perf_addr_o), .perf_we_o(perf_we_o),
      .perf_data_o(perf_data_o), .perf_data_i(perf_data_i),
      .sample_en_i(sample_en_i), .sample_period_i(sample_period_i),
      .counter_mask_i(counter_mask_i),
      .sample_valid_o(sample_valid_o), .sample_ready_i(sample_ready_i),
      .sample_idx_o(sample_idx_o), .sample_seq_o(sample_seq_o),
      .sample_last_o(sample_last_o), .sample_data_o(sample_data_o),
      .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
   );

   // Counter block model: combinational read, write on clock edge.
   logic [XL-1:0] cnt_mem [NC];
   always_comb begin
      perf_data_i = '0;
      for (int i = 0; i < NC; i++)
         if (perf_addr_o == 12'hB03 + 12'(i)) perf_data_i = cnt_mem[i];
   end
   always @(posedge clk) begin
      if (rst) begin
         cnt_mem[0] <= 64'h10; cnt_mem[1] <= 64'h15; cnt_mem[2] <= 64'h20;
         cnt_mem[3] <= 64'h25; cnt_mem[4] <= 64'h30; cnt_mem[5] <= 64'h35;
      end else if (perf_we_o) begin
         for (int i = 0; i < NC; i++)
            if (perf_addr_o == 12'hB03 + 12'(i)) cnt_mem[i] <= perf_data_o;
      end
   end

   always @(negedge clk)
      if (!rst && !csr_req_i && perf_we_o) we_bad = 1'b1;

   typedef struct {
      logic [3:0]    idx;
      logic [7:0]    seq;
      logic          last;
      logic [XL-1:0] data;
      logic          chk_data;
   } exp_t;
   exp_t exp_q[$];
   logic [XL-1:0] shadow [NC];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [3:0] idx, input logic [7:0] seq,
                           input logic last, input logic [XL-1:0] data);
      exp_t e;
      e.idx = idx; e.seq = seq; e.last = last; e.data = data; e.chk_data = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic exp_scan(input logic [7:0] seq, input logic [NC-1:0] mask);
      int hi;
      exp_t e;
      hi = -1;
      for (int i = 0; i < NC; i++) if (mask[i]) hi = i;
      if (HDR == 1) begin
         e.idx = 4'hF; e.seq = seq; e.last = 1'b0; e.data = '0; e.chk_data = 1'b0;
         exp_q.push_back(e);
      end
      for (int i = 0; i < NC; i++)
         if (mask[i]) push_exp(4'(i), seq, (i == hi), shadow[i]);
   endtask

   task automatic wait_busy(input logic lvl, input int budget, input string name);
      int n;
      n = 0;
      while (busy_o !== lvl && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, {63'b0, busy_o}, {63'b0, lvl});
   endtask

   // Monitor samples well after the falling edge; a pop occurs at the next rising edge.
   always begin : monitor
      exp_t e;
      @(negedge clk);
      #2;
      if (!rst && sample_valid_o && sample_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sample_unexpected: got idx=%0h seq=%0d last=%0b data=%0h",
                     sample_idx_o, sample_seq_o, sample_last_o, sample_data_o);
         end else begin
            e = exp_q.pop_front();
            if (sample_idx_o !== e.idx || sample_seq_o !== e.seq || sample_last_o !== e.last ||
                (e.chk_data && sample_data_o !== e.data)) begin
               failures++;
               $display("FAIL sample: got idx=%0h seq=%0d last=%0b data=%0h expected idx=%0h seq=%0d last=%0b data=%0h",
                        sample_idx_o, sample_seq_o, sample_last_o, sample_data_o,
                        e.idx, e.seq, e.last, e.data);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      shadow[0] = 64'h10; shadow[1] = 64'h15; shadow[2] = 64'h20;
      shadow[3] = 64'h25; shadow[4] = 64'h30; shadow[5] = 64'h35;
      repeat (2) @(negedge clk);
      check("rst_valid", {63'b0, sample_valid_o}, 64'd0);
      check("rst_idx", {60'b0, sample_idx_o}, 64'd0);
      check("rst_seq", {56'b0, sample_seq_o}, 64'd0);
      check("rst_data", sample_data_o, 64'd0);
      check("rst_drop", {56'b0, drop_cnt_o}, 64'd0);
      check("rst_busy", {63'b0, busy_o}, 64'd0);
      check("rst_addr", {52'b0, perf_addr_o}, 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Basic scan: two scans, then disable.
      push_exp(4'd0, 8'd0, 1'b0, 64'h10); push_exp(4'd2, 8'd0, 1'b1, 64'h20);
      push_exp(4'd0, 8'd1, 1'b0, 64'h10); push_exp(4'd2, 8'd1, 1'b1, 64'h20);
      if (HDR == 1) begin
         exp_q.delete();
         exp_scan(8'd0, 6'b000101);
         exp_scan(8'd1, 6'b000101);
      end
      sample_period_i = 16'd3; counter_mask_i = 6'b000101;
      sample_ready_i = 1'b1; sample_en_i = 1'b1;
      repeat (4) @(negedge clk);
      check("basic_wait_busy", {63'b0, busy_o}, 64'd0);
      @(negedge clk);
      check("basic_scan_start", {63'b0, busy_o}, 64'd1);
      check("basic_scan_we", {63'b0, perf_we_o}, 64'd0);
      if (HDR == 0) check("basic_scan_addr0", {52'b0, perf_addr_o}, 64'hB03);
      @(negedge clk);
      check("basic_first_valid", {63'b0, sample_valid_o}, 64'd1);
      if (HDR == 0) check("basic_scan_addr2", {52'b0, perf_addr_o}, 64'hB05);
      wait_busy(1'b0, 10, "basic_scan1_end");
      wait_busy(1'b1, 20, "basic_scan2_start");
      sample_en_i = 1'b0;
      wait_busy(1'b0, 10, "basic_scan2_end");
      repeat (6) @(negedge clk);

      // Zero-latency CSR read path.
      csr_req_i = 1'b1; csr_addr_i = 12'hB05; csr_we_i = 1'b0;
      #1;
      check("csr_read_addr", {52'b0, perf_addr_o}, 64'hB05);
      check("csr_read_data", csr_rdata_o, 64'h20);
      csr_req_i = 1'b0; csr_addr_i = '0;
      @(negedge clk);

      // CSR priority: two-cycle write to counter 1 at scan start stalls the scan.
      shadow[1] = 64'h55;
      exp_scan(8'd2, 6'b111111);
      sample_period_i = 16'd1; counter_mask_i = 6'b111111; sample_en_i = 1'b1;
      wait_busy(1'b1, 20, "csr_scan_start");
      sample_en_i = 1'b0;
      csr_req_i = 1'b1; csr_addr_i = 12'hB04; csr_we_i = 1'b1; csr_wdata_i = 64'h55;
      #1;
      check("csr_prio_addr", {52'b0, perf_addr_o}, 64'hB04);
      check("csr_prio_we", {63'b0, perf_we_o}, 64'd1);
      check("csr_prio_data", perf_data_o, 64'h55);
      n = 1;
      @(negedge clk);
      if (busy_o) n++;
      @(negedge clk);
      csr_req_i = 1'b0; csr_we_i = 1'b0; csr_addr_i = '0; csr_wdata_i = '0;
      while (busy_o && n < 30) begin
         n++;
         @(negedge clk);
      end
      check("csr_stall_busy_cycles", 64'(n), 64'(8 + HDR));
      repeat (10) @(negedge clk);

      // Drop on full: first scan fills, next expiry drops, then saturation.
      exp_scan(8'd3, 6'b111111);
      exp_scan(8'd4, 6'b111111);
      sample_ready_i = 1'b0; sample_period_i = 16'd0; sample_en_i = 1'b1;
      wait_busy(1'b1, 10, "drop_scan_start");
      wait_busy(1'b0, 20, "drop_scan_end");
      check("drop_before", {56'b0, drop_cnt_o}, 64'd0);
      @(negedge clk);
      check("drop_first", {56'b0, drop_cnt_o}, 64'd1);
      check("drop_no_scan", {63'b0, busy_o}, 64'd0);
      repeat (300) @(negedge clk);
      check("drop_saturate", {56'b0, drop_cnt_o}, 64'd255);
      sample_ready_i = 1'b1;
      wait_busy(1'b1, 40, "drop_resume_scan");
      sample_en_i = 1'b0;
      wait_busy(1'b0, 20, "drop_resume_end");
      repeat (10) @(negedge clk);
      check("drop_drained", 64'(exp_q.size()), 64'd0);

      // Disable mid-scan: remaining entries still pushed, then idle.
      exp_scan(8'd5, 6'b010110);
      sample_period_i = 16'd1; counter_mask_i = 6'b010110; sample_en_i = 1'b1;
      wait_busy(1'b1, 20, "dis_scan_start");
      n = 0;
      while (busy_o && n < 20) begin
         n++;
         if (n == 2) sample_en_i = 1'b0;
         @(negedge clk);
      end
      check("dis_busy_cycles", 64'(n), 64'(3 + HDR));
      repeat (8) @(negedge clk);
      check("dis_stays_idle", {63'b0, busy_o}, 64'd0);
      check("dis_fifo_empty", {63'b0, sample_valid_o}, 64'd0);

      // Reset mid-scan with three entries queued.
      sample_ready_i = 1'b0; sample_period_i = 16'd0; counter_mask_i = 6'b111111;
      sample_en_i = 1'b1;
      wait_busy(1'b1, 20, "rstscan_start");
      repeat (3) @(negedge clk);
      check("rstscan_queued", {63'b0, sample_valid_o}, 64'd1);
      #3 rst = 1'b1;
      #1;
      check("rstscan_valid", {63'b0, sample_valid_o}, 64'd0);
      check("rstscan_drop", {56'b0, drop_cnt_o}, 64'd255 & 64'd0);
      check("rstscan_busy", {63'b0, busy_o}, 64'd0);
      check("rstscan_seq_o", {56'b0, sample_seq_o}, 64'd0);
      sample_en_i = 1'b0;
      exp_q.delete();
      shadow[1] = 64'h15;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // After reset the sequence number restarts at zero.
      exp_scan(8'd0, 6'b000100);
      sample_ready_i = 1'b1; sample_period_i = 16'd2; counter_mask_i = 6'b000100;
      sample_en_i = 1'b1;
      wait_busy(1'b1, 20, "post_rst_scan_start");
      sample_en_i = 1'b0;
      wait_busy(1'b0, 10, "post_rst_scan_end");
      repeat (6) @(negedge clk);

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      check("sampler_never_writes", {63'b0, we_bad}, 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
